dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the byte-banked data memory between the RISC-V core's memory stage and the WOS filter window-fetch engine. It muxes one request per cycle onto the memory port and routes read data back to its owner. It stalls the core while the engine holds the port and guarantees the engine forward progress with a starvation counter and bounded bursts.

## Interface
- MAX_WAIT, 8: cycles an engine request may be refused before a grant is forced (1..255)
- BURST_MAX, 16: maximum engine beats per burst before ownership returns to the core (1..255)
- clk  in  1  single system clock
- rst  in  1  reset; synchronous and active-low: sampled on the rising edge of clk, asserted when 0
- c_req  in  1  core access request (load or store)
- c_we  in  1  core store
- c_addr  in  32  core byte address
- c_wdata  in  32  core store data
- c_func3  in  3  core load/store width code, passed to memory unchanged
- c_stall  out  1  core request not accepted this cycle
- c_rdata  out  32  core load data
- c_rvalid  out  1  c_rdata valid
- a_req, a_we, a_addr[31:0], a_wdata[31:0], a_func3[2:0]  in  engine request fields, same meaning as core fields
- a_last  in  1  current engine beat is the last of its burst
- a_gnt  out  1  engine beat accepted this cycle
- a_rdata  out  32  engine read data
- a_rvalid  out  1  a_rdata valid
- m_addr  out  32  memory byte address
- m_wdata  out  32  memory write data
- m_func3  out  3  memory width code
- m_w_en  out  1  memory write enable
- m_rdata  in  32  memory read data, valid one cycle after the request

## Operation
- FSM with two states: CORE (reset state) and ACC.
- Grant rules are combinational:
  - In CORE: grant the engine when a_req && (!c_req || wait_cnt == MAX_WAIT); otherwise grant the core when c_req.
  - In ACC: grant the engine when a_req; the core is never granted.
- Transitions:
  - CORE→ACC on an engine grant with a_last=0 and BURST_MAX>1.
  - ACC→CORE on an accepted beat with a_last=1, on beat_cnt reaching BURST_MAX, or on a_req=0.
- wait_cnt (8 bit):
  - Increments, saturating at MAX_WAIT, in each cycle a_req=1 and a_gnt=0.
  - Clears on any engine grant.
- beat_cnt (8 bit):
  - Counts accepted engine beats in the current burst, including the first beat granted in CORE.
  - Clears on return to CORE.
- Memory mux: m_* carries the granted requester's fields. With no grant: m_w_en=0, and m_addr, m_wdata and m_func3 hold the core fields.
- c_stall = c_req && !core_grant.
- Read return:
  - rd_tag is a registered pair {core_rd, acc_rd}, set from (grant && !we) of each requester.
  - c_rvalid = core_rd and a_rvalid = acc_rd in the following cycle.
  - c_rdata = a_rdata = m_rdata.
- Writes produce no rvalid.

## Timing
- Request accepted in cycle N (grant high at the rising edge ending N). Read data and rvalid appear in cycle N+1. Throughput is one access per cycle.
- Back-to-back grants to different owners are legal. Returns stay ordered because latency is fixed at 1.
- While rst=0 (combinational override):
  - a_gnt=0, c_stall=0, m_w_en=0.
- Register values after the first rising edge with rst=0:
  - state=CORE, wait_cnt=0, beat_cnt=0, rd_tag=0.
  - Therefore c_rvalid=0 and a_rvalid=0.
- Reset mid-burst: the next cycle is in CORE with no rvalid pending. The in-flight read return is discarded.
- Simultaneous c_req and a_req in CORE with wait_cnt<MAX_WAIT: the core wins, and wait_cnt increments.
- Starvation: the engine is granted no later than MAX_WAIT+1 cycles after it raises a_req, even with continuous c_req.
- Burst cap: the engine holds the port for at most BURST_MAX consecutive beats. At the cap, the next cycle is CORE with wait_cnt=0, so the core wins any simultaneous request there.
- a_req dropping mid-burst returns to CORE in the next cycle; no beat is counted.
- The core must hold its request fields stable while c_stall=1.

## Test plan
- Core only: c_req load at address 0x10 for 3 cycles. Required: c_stall=0 throughout, c_rvalid in cycles 1..3, c_rdata equals the preloaded words, a_gnt=0.
- Engine only, 4-beat burst (addresses 0x100..0x10C, a_last on beat 4). Required: a_gnt in 4 consecutive cycles, then state CORE; a_rvalid delayed by one cycle, with 4 pulses.
- Contention: c_req and a_req held continuously from cycle 0 with MAX_WAIT=8 and a_last=1 on every beat.
  - Cycles 0..7: core granted.
  - Cycle 8: engine granted and c_stall=1.
  - Cycle 9: core granted again.
  - The pattern repeats with period 9.
- Burst cap: BURST_MAX=16 with a_last held 0 and c_req=1 waiting. Required: exactly 16 engine beats, then a core grant in the next cycle with c_stall=0.
- Mixed write/read: the engine writes 0xDEADBEEF to 0x40, then the core reads 0x40 in the next cycle. Required: c_rvalid with c_rdata=0xDEADBEEF, and no a_rvalid for the write.
- Reset mid-burst: rst=0 at beat 3 of an 8-beat burst. Required: on the next edge, c_rvalid=0, a_rvalid=0, a_gnt=0, m_w_en=0; after rst release, a core request is granted immediately.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the data memory port between the core memory stage and the WOS window-fetch engine.
// Engine progress is guaranteed by a starvation counter and bursts are capped at BURST_MAX beats.
module dmem_arbiter #(
   parameter int MAX_WAIT  = 8,
   parameter int BURST_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_func3,
   output logic        c_stall,
   output logic [31:0] c_rdata,
   output logic        c_rvalid,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic [2:0]  a_func3,
   input  logic        a_last,
   output logic        a_gnt,
   output logic [31:0] a_rdata,
   output logic        a_rvalid,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [2:0]  m_func3,
   output logic        m_w_en,
   input  logic [31:0] m_rdata
);

   typedef enum logic {CORE, ACC} state_t;

   localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
   localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);
   localparam bit         MULTI_BEAT  = (BURST_MAX > 1);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic [7:0] beat_inc;
   logic [1:0] rd_tag_q, rd_tag_d;
   logic       core_grant, acc_grant;

   // Grants are forced off while reset is held so nothing reaches memory.
   always_comb begin
      core_grant = 1'b0;
      acc_grant  = 1'b0;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      beat_cnt_d = beat_cnt_q;
      beat_inc   = beat_cnt_q + 8'd1;
      if (rst) begin
         case (state_q)
            CORE: begin
               acc_grant  = a_req && (!c_req || (wait_cnt_q == MAX_WAIT_C));
               core_grant = c_req && !acc_grant;
               if (acc_grant && !a_last && MULTI_BEAT) begin
                  state_d    = ACC;
                  beat_cnt_d = 8'd1;
               end
            end
            ACC: begin
               acc_grant = a_req;
               if (!a_req || a_last || (beat_inc == BURST_MAX_C)) begin
                  state_d    = CORE;
                  beat_cnt_d = 8'd0;
               end else begin
                  beat_cnt_d = beat_inc;
               end
            end
            default: state_d = CORE;
         endcase
         if (acc_grant) begin
            wait_cnt_d = 8'd0;
         end else if (a_req && (wait_cnt_q < MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= CORE;
         wait_cnt_q <= 8'd0;
         beat_cnt_q <= 8'd0;
         rd_tag_q   <= 2'b00;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         rd_tag_q   <= rd_tag_d;
      end
   end

   // With no grant the core fields stay on the bus; only the write enable is gated.
   always_comb begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_func3 = c_func3;
      m_w_en  = 1'b0;
      if (acc_grant) begin
         m_addr  = a_addr;
         m_wdata = a_wdata;
         m_func3 = a_func3;
         m_w_en  = a_we;
      end else if (core_grant) begin
         m_w_en  = c_we;
      end
   end

   assign rd_tag_d = {core_grant && !c_we, acc_grant && !a_we};
   assign a_gnt    = acc_grant;
   assign c_stall  = rst && c_req && !core_grant;
   assign c_rvalid = rd_tag_q[1];
   assign a_rvalid = rd_tag_q[0];
   assign c_rdata  = m_rdata;
   assign a_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle-level reference of the grant rules plus a shadow
// memory predicts bus contents and read returns, which a separate monitor checks.
module tb_dmem_arbiter;

   localparam int MAX_WAIT  = 8;
   localparam int BURST_MAX = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        c_req, c_we, c_stall, c_rvalid;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic [2:0]  c_func3;
   logic        a_req, a_we, a_last, a_gnt, a_rvalid;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [2:0]  a_func3;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [2:0]  m_func3;
   logic        m_w_en;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
      .c_stall(c_stall), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_func3(a_func3),
      .a_last(a_last), .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_func3(m_func3), .m_w_en(m_w_en),
      .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Memory behind the arbiter: one-cycle read latency, word writes.
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (m_w_en) mem[m_addr[9:2]] <= m_wdata;
      m_rdata <= mem[m_addr[9:2]];
   end

   typedef struct { logic [31:0] d; int due; } exp_t;
   exp_t cq[$];
   exp_t aq[$];

   int checks = 0, failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] ref_mem [256];
   bit  m_burst = 0;
   int  m_wait = 0, m_beats = 0, refused = 0;
   bit  last_cg = 0, last_eg = 0;
   int  eng_left = 0;

   task automatic step();
      logic eg, cg;
      logic [69:0] exp_v, act_v;
      @(negedge clk);
      if (!rst) begin
         eg = 1'b0; cg = 1'b0;
      end else if (m_burst) begin
         eg = a_req; cg = 1'b0;
      end else begin
         eg = a_req && (!c_req || m_wait >= MAX_WAIT);
         cg = c_req && !eg;
      end
      exp_v = {eg, rst && c_req && !cg, eg ? a_we : (cg ? c_we : 1'b0),
               eg ? a_func3 : c_func3, eg ? a_addr : c_addr, eg ? a_wdata : c_wdata};
      act_v = {a_gnt, c_stall, m_w_en, m_func3, m_addr, m_wdata};
      checks++;
      if (act_v !== exp_v) begin
         failures++;
         $display("FAIL port_mux cyc=%0d {gnt,stall,wen,f3,addr,wdata} got=%h want=%h", cyc, act_v, exp_v);
      end
      if (rst && a_req) begin
         refused = a_gnt ? 0 : refused + 1;
         checks++;
         if (refused > MAX_WAIT) begin
            failures++;
            $display("FAIL starvation cyc=%0d refused=%0d limit=%0d", cyc, refused, MAX_WAIT);
         end
      end else begin
         refused = 0;
      end
      if (eg) begin
         if (a_we) ref_mem[a_addr[9:2]] = a_wdata;
         else aq.push_back('{ref_mem[a_addr[9:2]], cyc + 1});
      end
      if (cg) begin
         if (c_we) ref_mem[c_addr[9:2]] = c_wdata;
         else cq.push_back('{ref_mem[c_addr[9:2]], cyc + 1});
      end
      if (!rst) begin
         m_burst = 0; m_wait = 0; m_beats = 0;
      end else begin
         if (m_burst) begin
            if (!a_req) m_burst = 0;
            else begin
               m_beats++;
               if (a_last || m_beats == BURST_MAX) m_burst = 0;
            end
         end else if (eg && !a_last && BURST_MAX > 1) begin
            m_burst = 1; m_beats = 1;
         end
         if (eg) m_wait = 0;
         else if (a_req) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      end
      last_eg = eg;
      last_cg = cg;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_func3 = 3'd2;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_func3 = 3'd2; a_last = 0;
   endtask

   // Monitor: every read return must arrive exactly one cycle after its grant.
   always @(posedge clk) begin
      bit   due_c, due_a;
      exp_t e;
      #2;
      due_c = (cq.size() > 0) && (cq[0].due == cyc);
      checks++;
      if (c_rvalid !== due_c) begin
         failures++;
         $display("FAIL core_rvalid cyc=%0d got=%b want=%b", cyc, c_rvalid, due_c);
      end
      if (due_c) begin
         e = cq.pop_front();
         if (c_rvalid === 1'b1) begin
            checks++;
            if (c_rdata !== e.d) begin
               failures++;
               $display("FAIL core_rdata cyc=%0d got=%h want=%h", cyc, c_rdata, e.d);
            end
         end
      end
      due_a = (aq.size() > 0) && (aq[0].due == cyc);
      checks++;
      if (a_rvalid !== due_a) begin
         failures++;
         $display("FAIL acc_rvalid cyc=%0d got=%b want=%b", cyc, a_rvalid, due_a);
      end
      if (due_a) begin
         e = aq.pop_front();
         if (a_rvalid === 1'b1) begin
            checks++;
            if (a_rdata !== e.d) begin
               failures++;
               $display("FAIL acc_rdata cyc=%0d got=%h want=%h", cyc, a_rdata, e.d);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = {8'hA5, 8'(i), 16'(i * 37 + 11)};
         ref_mem[i] = {8'hA5, 8'(i), 16'(i * 37 + 11)};
      end
      idle();
      rst = 0;
      c_req = 1; c_we = 1; a_req = 1; a_we = 1;
      step(); step();
      idle();
      rst = 1;
      step();

      // Core-only loads
      c_req = 1; c_addr = 32'h10;
      for (int i = 0; i < 3; i++) step();
      idle(); step();

      // Engine-only 4-beat burst
      for (int b = 0; b < 4; b++) begin
         a_req = 1; a_addr = 32'h100 + 32'(4 * b); a_last = (b == 3);
         step();
      end
      idle(); step(); step();

      // Contention with single-beat engine requests
      c_req = 1; c_addr = 32'h20; a_req = 1; a_addr = 32'h200; a_last = 1;
      for (int i = 0; i < 27; i++) step();
      idle(); step();

      // Burst cap with core waiting
      c_req = 1; c_addr = 32'h24; a_req = 1; a_addr = 32'h300; a_last = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (last_eg) a_addr = (a_addr + 32'd4) & 32'h3FC;
      end
      idle(); step();

      // Engine write followed by core read of the same word
      a_req = 1; a_we = 1; a_addr = 32'h40; a_wdata = 32'hDEADBEEF; a_last = 1;
      step();
      idle();
      c_req = 1; c_addr = 32'h40;
      step();
      idle(); step();

      // Reset in the middle of an 8-beat burst
      for (int b = 0; b < 3; b++) begin
         a_req = 1; a_addr = 32'h380 + 32'(4 * b); a_last = 0;
         if (b == 2) begin
            rst = 0; c_req = 1; c_we = 1; c_addr = 32'h44; c_wdata = 32'h12345678;
         end
         step();
      end
      rst = 1;
      idle();
      c_req = 1; c_addr = 32'h10;
      step();
      idle(); step();

      // Randomized traffic with occasional resets and dropped engine requests
      eng_left = 0;
      for (int n = 0; n < 3000; n++) begin
         if (last_cg || !c_req) begin
            c_req   = ($urandom_range(0, 2) != 0);
            c_we    = 1'($urandom_range(0, 1));
            c_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            c_wdata = $urandom;
            c_func3 = 3'($urandom_range(0, 7));
         end
         if (last_eg && eng_left > 0) begin
            eng_left--;
            a_addr  = (a_addr + 32'd4) & 32'h3FC;
            a_we    = 1'($urandom_range(0, 1));
            a_wdata = $urandom;
            a_func3 = 3'($urandom_range(0, 7));
         end
         if (eng_left == 0 && $urandom_range(0, 3) == 0) begin
            eng_left = $urandom_range(1, 20);
            a_addr   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         end
         a_req  = (eng_left > 0) && ($urandom_range(0, 9) != 0);
         a_last = (eng_left == 1);
         rst    = ($urandom_range(0, 299) != 0);
         step();
      end
      rst = 1;
      idle();
      step(); step(); step();

      checks++;
      if (cq.size() != 0 || aq.size() != 0) begin
         failures++;
         $display("FAIL pending_returns core=%0d acc=%0d want 0 and 0", cq.size(), aq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
